// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding instruction-memory read, a one-entry
// output register to decode, and jump/jump-register/branch redirects with kill.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_control,
  input  logic        ctrl_valid,
  input  logic [25:0] target_addr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: imem request is accepted on a cycle with imem_req & imem_ready;
  // exactly one imem_rvalid beat returns per accepted request; decode takes the
  // instruction/pc pair on a cycle with instr_valid & instr_ready.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;

  assign redirect = ctrl_valid &&
                    (pc_control == 3'b001 || pc_control == 3'b010 || pc_control == 3'b011);

  // Branch offset is a signed word offset relative to the instruction after pc.
  always_comb begin
    target = 32'h0;
    case (pc_control)
      3'b001:  target = {pc_q[31:28], target_addr, 2'b00};
      3'b010:  target = jr_addr & 32'hFFFF_FFFC;
      3'b011:  target = pc_q + 32'd4 + {{14{target_addr[15]}}, target_addr[15:0], 2'b00};
      default: target = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = redirect ? target : fetch_pc_q;
    issued_pc_d = issued_pc_q;
    kill_d      = kill_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    imem_req    = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_d     = WAIT;
          issued_pc_d = fetch_pc_q;
          kill_d      = redirect;
          if (!redirect) fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rdata;
            pc_d    = issued_pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || instr_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= RESET_PC;
      kill_q      <= 1'b0;
      instr_q     <= 32'h0;
      pc_q        <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      kill_q      <= kill_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign dbg_state_o = state_q;

endmodule
